// File: rtl/equeue_int.sv
// Integer issue queue: age-ordered compacting buffer that wakes operands from the CDB
// and presents the oldest fully-ready op to the integer execution unit.
module equeue_int #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] equeue_imm,
  input  logic [5:0]  equeue_rdtag,
  input  logic [5:0]  equeue_rstag,
  input  logic [5:0]  equeue_rttag,
  input  logic [31:0] equeue_rsdata,
  input  logic [31:0] equeue_rtdata,
  input  logic        equeue_rsvalid,
  input  logic        equeue_rtvalid,
  input  logic [3:0]  equeueint_opcode,
  input  logic        equeueint_en,
  output logic        equeueint_ready,
  input  logic [5:0]  cdb_tag,
  input  logic        cdb_valid,
  input  logic [31:0] cdb_data,
  output logic        issue_req,
  input  logic        issue_grant,
  output logic [3:0]  issue_opcode,
  output logic [31:0] issue_rsdata,
  output logic [31:0] issue_rtdata,
  output logic [15:0] issue_imm,
  output logic [5:0]  issue_rdtag
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        v;
    logic [3:0]  opcode;
    logic [15:0] imm;
    logic [5:0]  rdtag;
    logic [5:0]  rstag;
    logic [5:0]  rttag;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic        rsv;
    logic        rtv;
  } entry_t;

  entry_t            q_r   [DEPTH];
  entry_t            q_nx  [DEPTH];
  entry_t            q_ext [DEPTH+1];
  entry_t            new_e;
  entry_t            sel_e;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nx;
  logic [CNT_W-1:0]  wpos;
  logic [SEL_W-1:0]  sel;
  logic              found;
  logic              do_issue;
  logic              do_write;

  // CDB snoop on a single entry; also used for same-cycle forwarding on write.
  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [5:0] ct, input logic [31:0] cd);
    entry_t r;
    r = e;
    if (r.v && cv && !r.rsv && r.rstag == ct) begin
      r.rsv    = 1'b1;
      r.rsdata = cd;
    end
    if (r.v && cv && !r.rtv && r.rttag == ct) begin
      r.rtv    = 1'b1;
      r.rtdata = cd;
    end
    return r;
  endfunction

  // Oldest-first selection of a fully ready entry.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sel_e = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!found && q_r[i].v && q_r[i].rsv && q_r[i].rtv) begin
        found = 1'b1;
        sel   = SEL_W'(i);
        sel_e = q_r[i];
      end
    end
  end

  assign equeueint_ready = (count != CNT_W'(DEPTH));
  assign issue_req       = found;
  assign issue_opcode    = sel_e.opcode;
  assign issue_rsdata    = sel_e.rsdata;
  assign issue_rtdata    = sel_e.rtdata;
  assign issue_imm       = sel_e.imm;
  assign issue_rdtag     = sel_e.rdtag;

  assign do_issue = found & issue_grant;
  assign do_write = equeueint_en & equeueint_ready;
  assign wpos     = count - CNT_W'(do_issue);
  assign count_nx = count + CNT_W'(do_write) - CNT_W'(do_issue);

  always_comb begin
    new_e        = '0;
    new_e.v      = 1'b1;
    new_e.opcode = equeueint_opcode;
    new_e.imm    = equeue_imm;
    new_e.rdtag  = equeue_rdtag;
    new_e.rstag  = equeue_rstag;
    new_e.rttag  = equeue_rttag;
    new_e.rsdata = equeue_rsdata;
    new_e.rtdata = equeue_rtdata;
    new_e.rsv    = equeue_rsvalid;
    new_e.rtv    = equeue_rtvalid;
    new_e        = wake(new_e, cdb_valid, cdb_tag, cdb_data);
  end

  // Compaction: entries at or above the issued slot take their younger neighbour.
  always_comb begin
    q_ext[DEPTH] = '0;
    for (int i = 0; i < int'(DEPTH); i++) q_ext[i] = q_r[i];
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (do_issue && SEL_W'(i) >= sel) q_nx[i] = wake(q_ext[i+1], cdb_valid, cdb_tag, cdb_data);
      else                              q_nx[i] = wake(q_ext[i], cdb_valid, cdb_tag, cdb_data);
      if (do_write && CNT_W'(i) == wpos) q_nx[i] = new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) q_r[i] <= '0;
    end else begin
      count <= count_nx;
      for (int i = 0; i < int'(DEPTH); i++) q_r[i] <= q_nx[i];
    end
  end

endmodule

// File: tb/tb_equeue_int.sv
// Bench for equeue_int: directed test-plan steps followed by random traffic,
// all compared against a queue-based age-ordered issue model.
module tb_equeue_int;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] equeue_imm;
  logic [5:0]  equeue_rdtag, equeue_rstag, equeue_rttag;
  logic [31:0] equeue_rsdata, equeue_rtdata;
  logic        equeue_rsvalid, equeue_rtvalid;
  logic [3:0]  equeueint_opcode;
  logic        equeueint_en;
  logic        equeueint_ready;
  logic [5:0]  cdb_tag;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic        issue_req;
  logic        issue_grant;
  logic [3:0]  issue_opcode;
  logic [31:0] issue_rsdata, issue_rtdata;
  logic [15:0] issue_imm;
  logic [5:0]  issue_rdtag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  opcode;
    logic [15:0] imm;
    logic [5:0]  rdtag, rstag, rttag;
    logic [31:0] rsdata, rtdata;
    logic        rsv, rtv;
  } op_t;

  op_t model[$];

  equeue_int #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .equeue_imm(equeue_imm), .equeue_rdtag(equeue_rdtag),
    .equeue_rstag(equeue_rstag), .equeue_rttag(equeue_rttag),
    .equeue_rsdata(equeue_rsdata), .equeue_rtdata(equeue_rtdata),
    .equeue_rsvalid(equeue_rsvalid), .equeue_rtvalid(equeue_rtvalid),
    .equeueint_opcode(equeueint_opcode), .equeueint_en(equeueint_en),
    .equeueint_ready(equeueint_ready),
    .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .issue_req(issue_req), .issue_grant(issue_grant),
    .issue_opcode(issue_opcode), .issue_rsdata(issue_rsdata),
    .issue_rtdata(issue_rtdata), .issue_imm(issue_imm),
    .issue_rdtag(issue_rdtag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ready_idx();
    for (int i = 0; i < model.size(); i++)
      if (model[i].rsv && model[i].rtv) return i;
    return -1;
  endfunction

  function automatic op_t snoop(input op_t o);
    op_t r = o;
    if (cdb_valid && !r.rsv && r.rstag == cdb_tag) begin r.rsv = 1'b1; r.rsdata = cdb_data; end
    if (cdb_valid && !r.rtv && r.rttag == cdb_tag) begin r.rtv = 1'b1; r.rtdata = cdb_data; end
    return r;
  endfunction

  // Compare outputs against the model mid-cycle, then advance the model across the edge.
  task automatic cycle();
    int  idx;
    bit  iss, wr;
    op_t n;
    @(negedge clk);
    idx = ready_idx();
    chk("ready", 32'(equeueint_ready), 32'(model.size() != DEPTH));
    chk("req", 32'(issue_req), 32'(idx >= 0));
    chk("opcode", 32'(issue_opcode), (idx >= 0) ? 32'(model[idx].opcode) : 32'd0);
    chk("rsdata", issue_rsdata, (idx >= 0) ? model[idx].rsdata : 32'd0);
    chk("rtdata", issue_rtdata, (idx >= 0) ? model[idx].rtdata : 32'd0);
    chk("imm", 32'(issue_imm), (idx >= 0) ? 32'(model[idx].imm) : 32'd0);
    chk("rdtag", 32'(issue_rdtag), (idx >= 0) ? 32'(model[idx].rdtag) : 32'd0);
    if (reset) begin
      model.delete();
    end else begin
      iss = (idx >= 0) && issue_grant;
      wr  = equeueint_en && (model.size() != DEPTH);
      if (iss) model.delete(idx);
      for (int i = 0; i < model.size(); i++) model[i] = snoop(model[i]);
      if (wr) begin
        n.opcode = equeueint_opcode; n.imm = equeue_imm; n.rdtag = equeue_rdtag;
        n.rstag = equeue_rstag; n.rttag = equeue_rttag;
        n.rsdata = equeue_rsdata; n.rtdata = equeue_rtdata;
        n.rsv = equeue_rsvalid; n.rtv = equeue_rtvalid;
        model.push_back(snoop(n));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    equeueint_en = 1'b0; cdb_valid = 1'b0; issue_grant = 1'b0; reset = 1'b0;
  endtask

  task automatic set_write(input logic [3:0] opc, input logic [5:0] rd, input logic [5:0] rs,
                           input logic [5:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic rsv, input logic rtv);
    equeueint_en = 1'b1; equeueint_opcode = opc; equeue_rdtag = rd;
    equeue_rstag = rs; equeue_rttag = rt; equeue_rsdata = rsd; equeue_rtdata = rtd;
    equeue_rsvalid = rsv; equeue_rtvalid = rtv; equeue_imm = {10'd0, rd};
  endtask

  task automatic set_cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    idle();
    cdb_tag = '0; cdb_data = '0; equeue_imm = '0; equeue_rdtag = '0;
    equeue_rstag = '0; equeue_rttag = '0; equeue_rsdata = '0; equeue_rtdata = '0;
    equeue_rsvalid = 1'b0; equeue_rtvalid = 1'b0; equeueint_opcode = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model.delete();
    chk("rst_ready", 32'(equeueint_ready), 32'd1);
    chk("rst_req", 32'(issue_req), 32'd0);
    chk("rst_rdtag", 32'(issue_rdtag), 32'd0);

    // Single ready op
    set_write(4'h2, 6'd5, 6'd0, 6'd0, 32'd7, 32'd9, 1'b1, 1'b1);
    cycle();
    idle();
    chk("op_req", 32'(issue_req), 32'd1);
    chk("op_rsdata", issue_rsdata, 32'd7);
    chk("op_rtdata", issue_rtdata, 32'd9);
    chk("op_rdtag", 32'(issue_rdtag), 32'd5);
    issue_grant = 1'b1;
    cycle();
    idle();
    chk("op_drained_req", 32'(issue_req), 32'd0);
    chk("op_drained_ready", 32'(equeueint_ready), 32'd1);

    // Fill with ops waiting on tag 12, then wake all at once
    for (int i = 0; i < DEPTH; i++) begin
      set_write(4'(i), 6'(20 + i), 6'd0, 6'd12, 32'(100 + i), 32'd0, 1'b1, 1'b0);
      cycle();
    end
    idle();
    chk("fill_ready", 32'(equeueint_ready), 32'd0);
    chk("fill_req", 32'(issue_req), 32'd0);
    equeueint_en = 1'b1;
    cycle();
    idle();
    set_cdb(6'd12, 32'hAB);
    cycle();
    idle();
    chk("wake_req", 32'(issue_req), 32'd1);
    chk("wake_rtdata", issue_rtdata, 32'hAB);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(issue_rdtag), 32'(20 + i));
      issue_grant = 1'b1;
      cycle();
    end
    idle();
    chk("drain_empty", 32'(issue_req), 32'd0);

    // Forwarding on write
    set_write(4'h3, 6'd40, 6'd3, 6'd0, 32'd0, 32'd1, 1'b0, 1'b1);
    set_cdb(6'd3, 32'h55);
    cycle();
    idle();
    chk("fwd_req", 32'(issue_req), 32'd1);
    chk("fwd_rsdata", issue_rsdata, 32'h55);
    issue_grant = 1'b1;
    cycle();
    idle();

    // Out-of-order issue
    set_write(4'h4, 6'd30, 6'd8, 6'd0, 32'd0, 32'd2, 1'b0, 1'b1);
    cycle();
    set_write(4'h5, 6'd31, 6'd0, 6'd0, 32'd3, 32'd4, 1'b1, 1'b1);
    cycle();
    idle();
    chk("ooo_young", 32'(issue_rdtag), 32'd31);
    issue_grant = 1'b1;
    cycle();
    idle();
    chk("ooo_none", 32'(issue_req), 32'd0);
    set_cdb(6'd8, 32'h88);
    cycle();
    idle();
    chk("ooo_old", 32'(issue_rdtag), 32'd30);
    chk("ooo_old_rs", issue_rsdata, 32'h88);
    issue_grant = 1'b1;
    cycle();
    idle();

    // Write + issue at count = DEPTH-1
    set_write(4'h6, 6'd50, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    cycle();
    for (int i = 1; i < DEPTH - 1; i++) begin
      set_write(4'h7, 6'(50 + i), 6'd0, 6'd41, 32'd1, 32'd0, 1'b1, 1'b0);
      cycle();
    end
    set_write(4'h8, 6'd60, 6'd0, 6'd0, 32'd6, 32'd6, 1'b1, 1'b1);
    issue_grant = 1'b1;
    cycle();
    idle();
    chk("simul_ready", 32'(equeueint_ready), 32'd1);
    chk("simul_new", 32'(issue_rdtag), 32'd60);
    issue_grant = 1'b1;
    cycle();
    idle();
    set_cdb(6'd41, 32'h41);
    cycle();
    idle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(1) == 1)
        set_write(4'($urandom), 6'($urandom_range(15)), 6'($urandom_range(15)),
                  6'($urandom_range(15)), $urandom, $urandom,
                  1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0));
      if ($urandom_range(4) < 2) set_cdb(6'($urandom_range(15)), $urandom);
      issue_grant = ($urandom_range(4) < 3);
      cycle();
    end

    // Reset in the middle of operation
    idle();
    for (int i = 0; i < 2; i++) begin
      set_write(4'h1, 6'd9, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1);
      cycle();
    end
    idle();
    reset = 1'b1;
    equeueint_en = 1'b1;
    issue_grant = 1'b1;
    cycle();
    idle();
    chk("midrst_ready", 32'(equeueint_ready), 32'd1);
    chk("midrst_req", 32'(issue_req), 32'd0);
    chk("midrst_rdtag", 32'(issue_rdtag), 32'd0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/equeue_int.md
# equeue_int

Integer issue queue; the receiving end of the dispatch unit's integer-queue handshake (`equeueint_en`/`equeueint_ready`). It buffers up to DEPTH decoded integer ops with their operand tags and data, and snoops the CDB to wake up waiting operands. It issues the oldest op whose operands are both ready to the integer execution unit through a req/grant handshake.

## Interface
- DEPTH, 4: number of entries (2..8).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- equeue_imm  in  16  immediate field.
- equeue_rdtag  in  6  destination tag.
- equeue_rstag / equeue_rttag  in  6  source tags.
- equeue_rsdata / equeue_rtdata  in  32  source data; meaningful when the matching valid bit is 1.
- equeue_rsvalid / equeue_rtvalid  in  1  1 = data present, 0 = waiting on the tag.
- equeueint_opcode  in  4  integer ALU opcode.
- equeueint_en  in  1  write request from dispatch.
- equeueint_ready  out  1  queue can accept a write this cycle.
- cdb_tag  in  6  broadcast tag.
- cdb_valid  in  1  broadcast valid.
- cdb_data  in  32  broadcast data.
- issue_req  out  1  an entry is ready to issue.
- issue_grant  in  1  execution unit accepts the presented op.
- issue_opcode  out  4  opcode of the presented op.
- issue_rsdata / issue_rtdata  out  32  operands of the presented op.
- issue_imm  out  16  immediate of the presented op.
- issue_rdtag  out  6  destination tag of the presented op.

## Operation
- **Storage:** age-ordered, compacting array. Entry 0 is the oldest. count = number of valid entries, 0..DEPTH.
- **Entry fields:** v, opcode, imm, rdtag, rstag, rttag, rsdata, rtdata, rsv, rtv.
- **Write accept:** `equeueint_ready = (count != DEPTH)`. A write is accepted when en & ready. When en=1 and ready=0, the input is ignored; dispatch holds it.
- **Write position:** the new entry goes to index count, or count-1 if an issue happens in the same cycle.
- **Same-cycle forwarding on write:** if the incoming rsvalid=0 and cdb_valid and cdb_tag==rstag, store rsv=1 and rsdata=cdb_data. The same rule applies to rt.
- **Wakeup:** every valid entry with rsv=0 and rstag==cdb_tag while cdb_valid sets rsv=1 and captures cdb_data. Same for rt. Both operands may wake in one cycle.
- **Selection:** the lowest-index entry with v & rsv & rtv.
  - issue_req = 1 if such an entry exists.
  - The issue_* outputs carry the selected entry's fields, combinationally from registered state.
  - When issue_req=0, the issue_* data outputs are 0.
- **Issue and compaction:** on issue_req & issue_grant, the selected entry is removed. All younger entries shift down by one in the same edge, and their CDB wakeups in that cycle are applied to the shifted copies.
- **Grant without request:** issue_grant with issue_req=0 is ignored.
- **Count update:** count changes by +1 on write only, -1 on issue only, 0 on both or neither.

## Timing
- **Reset:** the edge with reset=1 clears all v and count.
  - Afterwards: equeueint_ready=1, issue_req=0, all issue_* data outputs 0.
  - Writes and grants in a reset cycle are ignored.
  - Reset mid-operation discards all entries.
- **Write-to-issue latency:** an op written with both operands valid (or forwarded on write) asserts issue_req the cycle after the write edge. Minimum latency is 1.
- **Wakeup-to-issue latency:** an operand woken by the CDB at edge N makes its entry eligible from cycle N+1. No same-cycle CDB-to-issue bypass.
- **Ready is state-based:** a full queue deasserts ready even if a grant is arriving that cycle.
- **Grant timing:** issue_grant is sampled in the same cycle as issue_req. The presented op is stable until granted, unless an older entry becomes ready first.
- **Full with no ready entry:** ready=0 and issue_req=0 until a CDB wakeup occurs.

## Test plan
- **Reset state:** reset high 2 cycles then low -> ready=1, issue_req=0, issue_rdtag=0.
- **Ready op:** write opcode=4'h2, rdtag=6'd5, rsvalid=rtvalid=1, rsdata=32'd7, rtdata=32'd9 -> next cycle issue_req=1, rsdata=7, rtdata=9, rdtag=5. Grant -> issue_req=0 and count=0 the following cycle.
- **Fill and wake:** write DEPTH ops all with rtvalid=0, rttag=6'd12 -> ready=0 after the DEPTH-th write. Then cdb_valid, tag=12, data=32'hAB -> next cycle issue_req=1 with the oldest entry, rtdata=32'hAB. Granting each cycle drains the queue in write order.
- **Forwarding on write:** write with rsvalid=0, rstag=6'd3, while cdb_valid and cdb_tag=3, cdb_data=32'h55 -> next cycle issue_req=1, issue_rsdata=32'h55.
- **Out-of-order issue:** entry0 waiting on tag 8, entry1 ready -> entry1 issues first. After wakeup of tag 8, entry0 issues.
- **Simultaneous write and issue at count=DEPTH-1 with grant:** count unchanged, the new entry lands at index DEPTH-2, and ready stays 1.
